prmcu_uart_top: RTL and testbench
=================================

Name: prmcu_uart_top

Overview:
- Configurable full-duplex UART core for the prmcu peripheral set.
- Serializes 9-bit-wide words from a valid/ready input stream onto tx_o.
- Deserializes frames from rx_i onto a valid/ready output stream.
- Bit timing comes from a programmable divider of the single system clock (10 MHz nominal; divider 87 gives about 115200 baud).

Parameters:
- SYNC_STAGES, 2, number of flip-flops synchronizing rx_i into the clk domain.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- internal_clk_o  out  1  bit-rate tick; one-cycle pulse every internal_clk_divider_i clk cycles while uart_en=1.
- uart_en  in  1  global enable; 0 forces both engines idle.
- tx_en  in  1  transmitter enable.
- rx_en  in  1  receiver enable.
- n_parity_bits_i  in  1  1 = one even-parity bit after the data; 0 = no parity.
- n_stop_bits_i  in  2  stop bits: 0 or 1 gives 1 stop bit; 2 or 3 gives 2 stop bits.
- n_data_bits_i  in  4  data bits per frame, 5..9; values <5 clamp to 5, values >9 clamp to 9.
- internal_clk_divider_i  in  8  clk cycles per bit; values <2 treated as 2.
- in_dat_i  in  9  TX word; bits [n_data_bits-1:0] are sent.
- in_vld_i  in  1  TX word valid.
- in_rdy_o  out  1  TX ready.
- out_dat_o  out  9  RX word, zero-extended above n_data_bits.
- out_vld_o  out  1  RX word valid.
- out_rdy_i  in  1  RX consumer ready.
- tx_o  out  1  serial out; idle high.
- rx_i  in  1  serial in; asynchronous; idle high.

Behaviour:
- Reset (rst=0 at a clk edge):
  - tx_o=1, in_rdy_o=0, out_vld_o=0, out_dat_o=0, internal_clk_o=0.
  - All counters 0; both FSMs IDLE.
  - Reset mid-frame aborts the frame immediately.
- Frame format: start(0), data LSB first, optional parity bit, stop bits(1).
  - Parity = XOR of the transmitted data bits (even parity).
- Configuration latching: n_* and the divider are latched at the start of each frame; changes mid-frame take effect on the next frame.
- Baud counter: counts 0..DIV-1 per bit; the tick is asserted when the count reaches DIV-1.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if no parity) -> STOP -> IDLE.
  - in_rdy_o = uart_en & tx_en & (state==IDLE).
  - A word is accepted on in_vld_i & in_rdy_o.
  - tx_o drives the start bit on the next cycle; each bit is held DIV cycles.
  - Back-to-back words: IDLE lasts one cycle between frames.
- RX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE, on the synchronized rx signal.
  - Falling edge in IDLE (rx_en & uart_en): wait DIV/2 cycles, then re-sample. If high, it was a glitch; return to IDLE.
  - Each subsequent bit is sampled every DIV cycles (mid-bit).
  - The parity bit is sampled and discarded; no error port exists and the frame is still delivered.
  - The first stop bit is sampled. If low, a framing error: discard the frame and wait for the line to be high before re-arming.
  - Only the first stop bit is checked; after it is sampled the FSM returns to IDLE and accepts a new start edge immediately.
- RX output register:
  - On a good stop sample: out_dat_o <= data, out_vld_o <= 1 on the next cycle.
  - out_vld_o holds until out_vld_o & out_rdy_i, then clears.
  - If out_vld_o is still 1 when a new frame completes: the new frame is dropped (overrun) and the old word is kept.
- Disables:
  - uart_en=0, tx_en=0 or rx_en=0 mid-frame aborts that engine to IDLE; tx_o returns to 1.
  - out_vld_o and out_dat_o are kept.

Decomposition:
- Package prmcu_uart_pkg holds:
  - the TX/RX state enums (IDLE, START, DATA, PARITY, STOP);
  - MIN_DATA_BITS=5, MAX_DATA_BITS=9, MIN_DIV=2.
- Sub-module prmcu_uart_baud_gen (divider counter with restart and half-period option), instantiated once in TX and once in RX.
- TX and RX FSMs live in the top.

Test Plan:
- RX, 6 data bits, no parity, 2 stop bits, divider 87, rx_i driven at 115 kbaud with 100 random words, out_rdy_i=1 -> 100 out_vld_o pulses; out_dat_o[5:0] equals each word in order.
- RX, 8 data bits, parity on, 1 stop bit, rx frame 0xA5 with parity 0 -> out_dat_o=0x0A5.
- RX with stop bit forced 0 on word 0x3C -> no out_vld_o; the next good frame 0x12 is delivered.
- RX with out_rdy_i=0, two frames 0x11 then 0x22 -> out_vld_o stays 1 with 0x011; after out_rdy_i=1 it clears and 0x22 is not delivered.
- TX, 8 bits, parity on, 1 stop bit, divider 10, in_dat_i=0x0F1 -> tx_o sequence 0,1,0,0,0,1,1,1,1,1(parity),1, each 10 cycles; in_rdy_o low during the frame.
- rst=0 mid-TX frame -> tx_o=1, in_rdy_o=0 next cycle; after release in_rdy_o=1 with uart_en=tx_en=1.

Source files
------------

// File: rtl/prmcu_uart_pkg.sv
// rtl/prmcu_uart_pkg.sv - shared states, limits and helpers for the prmcu UART
package prmcu_uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;
  localparam int MIN_DIV       = 2;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] n);
    if (n < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    if (n > 4'(MAX_DATA_BITS)) return 4'(MAX_DATA_BITS);
    return n;
  endfunction

  function automatic logic [7:0] clamp_div(input logic [7:0] d);
    if (d < 8'(MIN_DIV)) return 8'(MIN_DIV);
    return d;
  endfunction

  // Ones in the low n positions; n never exceeds MAX_DATA_BITS
  function automatic logic [8:0] data_mask(input logic [3:0] n);
    logic [9:0] m;
    m = (10'd1 << n) - 10'd1;
    return m[8:0];
  endfunction

endpackage

// File: rtl/prmcu_uart_baud_gen.sv
// rtl/prmcu_uart_baud_gen.sv - bit-period counter with restart and half-period first interval
module prmcu_uart_baud_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       restart,
  input  logic       half,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt_q;
  logic       half_q;
  logic [7:0] limit;

  // Terminal count: a half period right after a restart with half set, a full period otherwise
  always_comb begin
    limit = half_q ? ((div >> 1) - 8'd1) : (div - 8'd1);
  end

  // >= rather than == so a divider shrinking under a running count cannot stall it
  assign tick = en & (cnt_q >= limit);

  // Count 0..limit, restart on request, drop back to full periods after the first tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
    end else if (!en) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
    end else if (restart) begin
      cnt_q  <= '0;
      half_q <= half;
    end else if (tick) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/prmcu_uart_top.sv
// rtl/prmcu_uart_top.sv - full-duplex UART core with valid/ready word streams
module prmcu_uart_top
  import prmcu_uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       internal_clk_o,
  input  logic       uart_en,
  input  logic       tx_en,
  input  logic       rx_en,
  input  logic       n_parity_bits_i,
  input  logic [1:0] n_stop_bits_i,
  input  logic [3:0] n_data_bits_i,
  input  logic [7:0] internal_clk_divider_i,
  input  logic [8:0] in_dat_i,
  input  logic       in_vld_i,
  output logic       in_rdy_o,
  output logic [8:0] out_dat_o,
  output logic       out_vld_o,
  input  logic       out_rdy_i,
  output logic       tx_o,
  input  logic       rx_i
);

  logic       rst_done_q;
  logic [7:0] div_live;
  logic [3:0] nbits_live;
  logic       two_stop_live;

  assign div_live      = clamp_div(internal_clk_divider_i);
  assign nbits_live    = clamp_data_bits(n_data_bits_i);
  assign two_stop_live = (n_stop_bits_i >= 2'd2);

  // Keeps in_rdy_o and the tick low while reset is held, even though the FSMs already sit in IDLE
  always_ff @(posedge clk) begin
    if (!rst) rst_done_q <= 1'b0;
    else      rst_done_q <= 1'b1;
  end

  // ---------------- transmitter ----------------
  tx_state_t  tx_state, tx_next;
  logic       tx_active, tx_accept, tx_tick;
  logic [8:0] tx_data_q;
  logic       tx_par_q, tx_par_en_q, tx_two_stop_q, tx_stop_idx_q;
  logic [3:0] tx_nbits_q, tx_idx_q;
  logic [7:0] tx_div_q, tx_div_sel;

  assign tx_active  = uart_en & tx_en;
  assign in_rdy_o   = rst_done_q & tx_active & (tx_state == TX_IDLE);
  assign tx_accept  = in_vld_i & in_rdy_o;
  // While idle the generator follows the live divider so internal_clk_o tracks it
  assign tx_div_sel = (tx_state == TX_IDLE) ? div_live : tx_div_q;

  prmcu_uart_baud_gen u_tx_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (uart_en),
    .restart (tx_accept),
    .half    (1'b0),
    .div     (tx_div_sel),
    .tick    (tx_tick)
  );

  assign internal_clk_o = tx_tick & rst_done_q;

  // TX state register, frame configuration latch and bit/stop counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state      <= TX_IDLE;
      tx_data_q     <= '0;
      tx_par_q      <= 1'b0;
      tx_par_en_q   <= 1'b0;
      tx_two_stop_q <= 1'b0;
      tx_nbits_q    <= 4'(MIN_DATA_BITS);
      tx_div_q      <= 8'(MIN_DIV);
      tx_idx_q      <= '0;
      tx_stop_idx_q <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_accept) begin
        tx_data_q     <= in_dat_i;
        tx_par_q      <= ^(in_dat_i & data_mask(nbits_live));
        tx_par_en_q   <= n_parity_bits_i;
        tx_two_stop_q <= two_stop_live;
        tx_nbits_q    <= nbits_live;
        tx_div_q      <= div_live;
        tx_idx_q      <= '0;
        tx_stop_idx_q <= 1'b0;
      end else if (tx_tick) begin
        if (tx_state == TX_DATA) tx_idx_q <= tx_idx_q + 4'd1;
        if (tx_state == TX_STOP) tx_stop_idx_q <= 1'b1;
      end
    end
  end

  // TX next state and serial line level
  always_comb begin
    tx_next = tx_state;
    tx_o    = 1'b1;
    case (tx_state)
      TX_IDLE:   tx_o = 1'b1;
      TX_START:  tx_o = 1'b0;
      TX_DATA:   tx_o = tx_data_q[tx_idx_q];
      TX_PARITY: tx_o = tx_par_q;
      TX_STOP:   tx_o = 1'b1;
      default:   tx_o = 1'b1;
    endcase
    if (!tx_active) begin
      tx_next = TX_IDLE;
      tx_o    = 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE:   if (tx_accept) tx_next = TX_START;
        TX_START:  if (tx_tick) tx_next = TX_DATA;
        TX_DATA:   if (tx_tick && (tx_idx_q == tx_nbits_q - 4'd1))
                     tx_next = tx_par_en_q ? TX_PARITY : TX_STOP;
        TX_PARITY: if (tx_tick) tx_next = TX_STOP;
        TX_STOP:   if (tx_tick && (tx_stop_idx_q == tx_two_stop_q)) tx_next = TX_IDLE;
        default:   tx_next = TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_t              rx_state, rx_next;
  logic [SYNC_STAGES-1:0] rx_sync_q;
  logic                   rx_s, rx_prev_q, rx_fall;
  logic                   rx_active, rx_restart, rx_tick, rx_good;
  logic [8:0]             rx_data_q;
  logic [3:0]             rx_nbits_q, rx_idx_q;
  logic                   rx_par_en_q;
  logic [7:0]             rx_div_q, rx_div_sel;

  assign rx_s       = rx_sync_q[SYNC_STAGES-1];
  // A falling edge needs the line seen high first, which also re-arms after a framing error
  assign rx_fall    = rx_prev_q & ~rx_s;
  assign rx_active  = uart_en & rx_en;
  assign rx_restart = rx_active & (rx_state == RX_IDLE) & rx_fall;
  assign rx_good    = rx_active & (rx_state == RX_STOP) & rx_tick & rx_s;
  assign rx_div_sel = (rx_state == RX_IDLE) ? div_live : rx_div_q;

  // Synchronize the asynchronous line; idle level is high
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_sync_q <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

  prmcu_uart_baud_gen u_rx_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (uart_en),
    .restart (rx_restart),
    .half    (1'b1),
    .div     (rx_div_sel),
    .tick    (rx_tick)
  );

  // RX state register, configuration latch and mid-bit data capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state    <= RX_IDLE;
      rx_data_q   <= '0;
      rx_idx_q    <= '0;
      rx_nbits_q  <= 4'(MIN_DATA_BITS);
      rx_par_en_q <= 1'b0;
      rx_div_q    <= 8'(MIN_DIV);
    end else begin
      rx_state <= rx_next;
      if (rx_restart) begin
        rx_data_q   <= '0;
        rx_idx_q    <= '0;
        rx_nbits_q  <= nbits_live;
        rx_par_en_q <= n_parity_bits_i;
        rx_div_q    <= div_live;
      end else if (rx_tick && (rx_state == RX_DATA)) begin
        rx_data_q[rx_idx_q] <= rx_s;
        rx_idx_q            <= rx_idx_q + 4'd1;
      end
    end
  end

  // RX next state; parity is sampled and ignored, only the first stop bit is checked
  always_comb begin
    rx_next = rx_state;
    if (!rx_active) begin
      rx_next = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE:   if (rx_fall) rx_next = RX_START;
        RX_START:  if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
        RX_DATA:   if (rx_tick && (rx_idx_q == rx_nbits_q - 4'd1))
                     rx_next = rx_par_en_q ? RX_PARITY : RX_STOP;
        RX_PARITY: if (rx_tick) rx_next = RX_STOP;
        RX_STOP:   if (rx_tick) rx_next = RX_IDLE;
        default:   rx_next = RX_IDLE;
      endcase
    end
  end

  // Output word holding register; a frame finishing while a word is pending is dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_vld_o <= 1'b0;
      out_dat_o <= '0;
    end else begin
      if (out_vld_o && out_rdy_i) out_vld_o <= 1'b0;
      if (rx_good && !out_vld_o) begin
        out_vld_o <= 1'b1;
        out_dat_o <= rx_data_q;
      end
    end
  end

endmodule

// File: tb/tb_prmcu_uart_top.sv
// tb/tb_prmcu_uart_top.sv - self-checking bench for prmcu_uart_top
module tb_prmcu_uart_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       internal_clk_o;
  logic       uart_en, tx_en, rx_en;
  logic       n_parity_bits_i;
  logic [1:0] n_stop_bits_i;
  logic [3:0] n_data_bits_i;
  logic [7:0] internal_clk_divider_i;
  logic [8:0] in_dat_i;
  logic       in_vld_i;
  logic       in_rdy_o;
  logic [8:0] out_dat_o;
  logic       out_vld_o;
  logic       out_rdy_i;
  logic       tx_o;
  logic       rx_i;

  int         tests = 0;
  int         fails = 0;
  logic       collect = 1'b0;
  logic [8:0] got_q[$];

  typedef struct {
    logic [3:0] nbits;
    logic       par;
    logic [1:0] nstop;
    logic [7:0] div;
    logic [8:0] word;
    logic [8:0] exp;
  } rx_vec_t;

  rx_vec_t vecs[6];

  always #50 clk = ~clk;

  prmcu_uart_top dut (
    .clk                    (clk),
    .rst                    (rst),
    .internal_clk_o         (internal_clk_o),
    .uart_en                (uart_en),
    .tx_en                  (tx_en),
    .rx_en                  (rx_en),
    .n_parity_bits_i        (n_parity_bits_i),
    .n_stop_bits_i          (n_stop_bits_i),
    .n_data_bits_i          (n_data_bits_i),
    .internal_clk_divider_i (internal_clk_divider_i),
    .in_dat_i               (in_dat_i),
    .in_vld_i               (in_vld_i),
    .in_rdy_o               (in_rdy_o),
    .out_dat_o              (out_dat_o),
    .out_vld_o              (out_vld_o),
    .out_rdy_i              (out_rdy_i),
    .tx_o                   (tx_o),
    .rx_i                   (rx_i)
  );

  // Record every word handed over on the output stream
  always @(negedge clk) begin
    if (collect && out_vld_o && out_rdy_i) got_q.push_back(out_dat_o);
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic int eff_bits(input logic [3:0] n);
    if (n < 4'd5) return 5;
    if (n > 4'd9) return 9;
    return int'(n);
  endfunction

  function automatic int eff_div(input logic [7:0] d);
    return (d < 8'd2) ? 2 : int'(d);
  endfunction

  function automatic logic [8:0] low_bits(input logic [8:0] w, input int n);
    int m;
    m = (1 << n) - 1;
    return w & m[8:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int d);
    rx_i = b;
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_rx_frame(input logic [8:0] word, input logic [3:0] nb_raw, input logic par,
                                input logic [1:0] ns_raw, input logic [7:0] div_raw, input logic bad_stop);
    int         nb;
    int         d;
    int         ns;
    logic [8:0] data;
    nb   = eff_bits(nb_raw);
    d    = eff_div(div_raw);
    ns   = (ns_raw >= 2'd2) ? 2 : 1;
    data = low_bits(word, nb);
    n_data_bits_i          = nb_raw;
    n_parity_bits_i        = par;
    n_stop_bits_i          = ns_raw;
    internal_clk_divider_i = div_raw;
    send_bit(1'b0, d);
    for (int i = 0; i < nb; i++) send_bit(data[i], d);
    if (par) send_bit(^data, d);
    for (int i = 0; i < ns; i++) send_bit(~bad_stop, d);
    rx_i = 1'b1;
  endtask

  task automatic tx_check(input string name, input logic [8:0] word, input logic [3:0] nb_raw, input logic par,
                          input logic [1:0] ns_raw, input logic [7:0] div_raw);
    int         nb;
    int         d;
    int         ns;
    int         w;
    logic [8:0] data;
    logic       exp_bits[$];
    nb   = eff_bits(nb_raw);
    d    = eff_div(div_raw);
    ns   = (ns_raw >= 2'd2) ? 2 : 1;
    w    = 0;
    data = low_bits(word, nb);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) exp_bits.push_back(data[i]);
    if (par) exp_bits.push_back(^data);
    for (int i = 0; i < ns; i++) exp_bits.push_back(1'b1);
    n_data_bits_i          = nb_raw;
    n_parity_bits_i        = par;
    n_stop_bits_i          = ns_raw;
    internal_clk_divider_i = div_raw;
    in_dat_i               = word;
    in_vld_i               = 1'b1;
    @(negedge clk);
    while (!in_rdy_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({name, "_accept"}, in_rdy_o, 1);
    @(posedge clk);
    #1;
    in_vld_i = 1'b0;
    for (int b = 0; b < exp_bits.size(); b++) begin
      for (int c = 0; c < d; c++) begin
        if (b != 0 || c != 0) begin
          @(posedge clk);
          #1;
        end
        check($sformatf("%s_bit%0d_cyc%0d", name, b, c), tx_o, exp_bits[b]);
        if (c == 0) check($sformatf("%s_rdy_low_bit%0d", name, b), in_rdy_o, 0);
      end
    end
    @(posedge clk);
    #1;
    check({name, "_rdy_after"}, in_rdy_o, 1);
    check({name, "_idle_high"}, tx_o, 1);
  endtask

  initial begin
    int         pulses;
    int         w;
    logic [8:0] word;
    logic [8:0] exp_q[$];

    vecs[0] = '{4'd8,  1'b1, 2'd0, 8'd16, 9'h0A5, 9'h0A5};
    vecs[1] = '{4'd3,  1'b0, 2'd1, 8'd16, 9'h1F5, 9'h015};
    vecs[2] = '{4'd15, 1'b1, 2'd2, 8'd12, 9'h1A5, 9'h1A5};
    vecs[3] = '{4'd9,  1'b0, 2'd3, 8'd0,  9'h155, 9'h155};
    vecs[4] = '{4'd7,  1'b1, 2'd0, 8'd87, 9'h0FF, 9'h07F};
    vecs[5] = '{4'd5,  1'b0, 2'd0, 8'd1,  9'h00A, 9'h00A};

    rst = 1'b0; uart_en = 1'b1; tx_en = 1'b1; rx_en = 1'b1;
    n_parity_bits_i = 1'b0; n_stop_bits_i = 2'd0; n_data_bits_i = 4'd8;
    internal_clk_divider_i = 8'd16; in_dat_i = '0; in_vld_i = 1'b0;
    out_rdy_i = 1'b1; rx_i = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_o", tx_o, 1);
    check("reset_in_rdy", in_rdy_o, 0);
    check("reset_out_vld", out_vld_o, 0);
    check("reset_out_dat", out_dat_o, 0);
    check("reset_internal_clk", internal_clk_o, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_reset", in_rdy_o, 1);

    // Bit-rate tick period while idle
    internal_clk_divider_i = 8'd10;
    repeat (20) @(posedge clk);
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (internal_clk_o) pulses++;
    end
    check("internal_clk_pulses", pulses, 10);
    @(posedge clk);
    #1;

    // Table of single RX frames, including clamped configurations
    for (int v = 0; v < 6; v++) begin
      collect = 1'b1;
      got_q.delete();
      drive_rx_frame(vecs[v].word, vecs[v].nbits, vecs[v].par, vecs[v].nstop, vecs[v].div, 1'b0);
      idle_cycles(2 * eff_div(vecs[v].div) + 4);
      check($sformatf("rx_vec%0d_count", v), got_q.size(), 1);
      if (got_q.size() > 0) check($sformatf("rx_vec%0d_data", v), got_q[0], vecs[v].exp);
    end

    // Random back-to-back RX words: 6 bits, no parity, 2 stop bits, divider 87
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < 100; k++) begin
      word = 9'($urandom_range(0, 511));
      exp_q.push_back(low_bits(word, 6));
      drive_rx_frame(word, 4'd6, 1'b0, 2'd2, 8'd87, 1'b0);
    end
    idle_cycles(200);
    check("rx_rand_count", got_q.size(), 100);
    for (int k = 0; k < 100 && k < got_q.size(); k++)
      check($sformatf("rx_rand_word%0d", k), got_q[k], exp_q[k]);

    // Framing error is discarded; the following good frame is delivered
    got_q.delete();
    drive_rx_frame(9'h03C, 4'd8, 1'b0, 2'd0, 8'd16, 1'b1);
    idle_cycles(32);
    drive_rx_frame(9'h012, 4'd8, 1'b0, 2'd0, 8'd16, 1'b0);
    idle_cycles(36);
    check("rx_frame_err_count", got_q.size(), 1);
    if (got_q.size() > 0) check("rx_frame_err_next", got_q[0], 9'h012);
    collect = 1'b0;

    // Overrun: first word held, second dropped
    out_rdy_i = 1'b0;
    drive_rx_frame(9'h011, 4'd8, 1'b0, 2'd0, 8'd16, 1'b0);
    idle_cycles(20);
    drive_rx_frame(9'h022, 4'd8, 1'b0, 2'd0, 8'd16, 1'b0);
    idle_cycles(36);
    check("overrun_vld_held", out_vld_o, 1);
    check("overrun_old_word", out_dat_o, 9'h011);
    @(negedge clk);
    out_rdy_i = 1'b1;
    @(posedge clk);
    #1;
    check("overrun_vld_clear", out_vld_o, 0);
    idle_cycles(48);
    check("overrun_not_delivered", out_vld_o, 0);

    // TX frame from the reference case, then a few random ones
    tx_check("tx_f1", 9'h0F1, 4'd8, 1'b1, 2'd0, 8'd10);
    for (int k = 0; k < 3; k++)
      tx_check($sformatf("tx_rand%0d", k), 9'($urandom_range(0, 511)), 4'($urandom_range(3, 11)),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(1, 12)));

    // Reset in the middle of a TX frame
    n_data_bits_i = 4'd8; n_parity_bits_i = 1'b0; n_stop_bits_i = 2'd0;
    internal_clk_divider_i = 8'd10; in_dat_i = 9'h0AA; in_vld_i = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_rdy_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_vld_i = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midtx_reset_tx_o", tx_o, 1);
    check("midtx_reset_rdy", in_rdy_o, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midtx_release_rdy", in_rdy_o, 1);
    repeat (30) @(posedge clk);
    #1;
    check("midtx_stays_idle", tx_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
